// File: rtl/calc_key_ctrl.sv
// Keypad-side initiator for the Calkko arithmetic core: assembles two 4-digit
// operands from key events, drives operands/op/state, and captures the result.
module calc_key_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TW      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  input  logic        set,
  input  logic [15:0] number,
  output logic [3:0]  A1,
  output logic [3:0]  A2,
  output logic [3:0]  A3,
  output logic [3:0]  A4,
  output logic [3:0]  B1,
  output logic [3:0]  B2,
  output logic [3:0]  B3,
  output logic [3:0]  B4,
  output logic [1:0]  ST,
  output logic [2:0]  ST_L,
  output logic [15:0] disp,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] S_WPA = 2'd0;
  localparam logic [1:0] S_WPB = 2'd1;
  localparam logic [1:0] S_OBL = 2'd2;
  localparam logic [1:0] S_WYN = 2'd3;

  localparam logic [2:0] SL_ADD = 3'd0;
  localparam logic [2:0] SL_SUB = 3'd1;
  localparam logic [2:0] SL_XOR = 3'd2;
  localparam logic [2:0] SL_OR  = 3'd3;
  localparam logic [2:0] SL_AND = 3'd4;

  typedef enum logic [2:0] {ENTER_A, ENTER_B, COMPUTE, SHOW, ERROR} state_t;

  state_t         r_state, w_state_n;
  logic [15:0]    r_a, r_b, r_res, w_a_n, w_b_n, w_res_n;
  logic [2:0]     r_acnt, r_bcnt, w_acnt_n, w_bcnt_n;
  logic [TW-1:0]  r_tmo, w_tmo_n;
  logic [2:0]     r_stl, w_stl_n;
  logic [1:0]     r_st, w_st_n;
  logic [15:0]    r_disp, w_disp_n;
  logic           r_busy, r_err, w_busy_n, w_err_n;

  logic           w_digit, w_op, w_eq, w_clr;
  logic [3:0]     w_d;
  logic [2:0]     w_op_sel;

  assign w_digit = key_valid && (key_code <= 5'd9);
  assign w_op    = key_valid && (key_code >= 5'd10) && (key_code <= 5'd14);
  assign w_eq    = key_valid && (key_code == 5'd15);
  assign w_clr   = key_valid && (key_code == 5'd16);
  assign w_d     = key_code[3:0];

  always_comb begin
    w_op_sel = SL_ADD;
    case (key_code)
      5'd11:   w_op_sel = SL_SUB;
      5'd12:   w_op_sel = SL_XOR;
      5'd13:   w_op_sel = SL_OR;
      5'd14:   w_op_sel = SL_AND;
      default: w_op_sel = SL_ADD;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_a_n     = r_a;
    w_b_n     = r_b;
    w_res_n   = r_res;
    w_acnt_n  = r_acnt;
    w_bcnt_n  = r_bcnt;
    w_tmo_n   = r_tmo;
    w_stl_n   = r_stl;

    unique case (r_state)
      ENTER_A: begin
        if (w_digit) begin
          if (r_acnt != 3'd4) begin
            w_a_n    = {r_a[11:0], w_d};
            w_acnt_n = r_acnt + 3'd1;
          end
        end else if (w_op) begin
          w_stl_n   = w_op_sel;
          w_b_n     = '0;
          w_bcnt_n  = '0;
          w_state_n = ENTER_B;
        end
      end
      ENTER_B: begin
        if (w_digit) begin
          if (r_bcnt != 3'd4) begin
            w_b_n    = {r_b[11:0], w_d};
            w_bcnt_n = r_bcnt + 3'd1;
          end
        end else if (w_op) begin
          w_stl_n = w_op_sel;
        end else if (w_eq) begin
          w_tmo_n   = '0;
          w_state_n = COMPUTE;
        end
      end
      COMPUTE: begin
        // set is checked before expiry so a coincident set still yields a result
        if (set) begin
          w_res_n   = number;
          w_state_n = SHOW;
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          w_state_n = ERROR;
        end else begin
          w_tmo_n = r_tmo + 1'b1;
        end
      end
      SHOW, ERROR: begin
        if (w_digit) begin
          w_a_n     = {12'h000, w_d};
          w_acnt_n  = 3'd1;
          w_b_n     = '0;
          w_bcnt_n  = '0;
          w_state_n = ENTER_A;
        end else if (r_state == SHOW && w_op) begin
          w_a_n     = r_res;
          w_acnt_n  = 3'd4;
          w_stl_n   = w_op_sel;
          w_b_n     = '0;
          w_bcnt_n  = '0;
          w_state_n = ENTER_B;
        end else if (r_state == SHOW && w_eq) begin
          w_a_n     = r_res;
          w_acnt_n  = 3'd4;
          w_tmo_n   = '0;
          w_state_n = COMPUTE;
        end
      end
      default: w_state_n = ENTER_A;
    endcase

    if (w_clr) begin
      w_a_n     = '0;
      w_b_n     = '0;
      w_res_n   = '0;
      w_acnt_n  = '0;
      w_bcnt_n  = '0;
      w_tmo_n   = '0;
      w_stl_n   = SL_ADD;
      w_state_n = ENTER_A;
    end
  end

  // Visible outputs are decoded from the next state so they register alongside it
  always_comb begin
    w_st_n   = S_WPA;
    w_disp_n = w_a_n;
    w_busy_n = 1'b0;
    w_err_n  = 1'b0;
    unique case (w_state_n)
      ENTER_A: begin w_st_n = S_WPA; w_disp_n = w_a_n; end
      ENTER_B: begin w_st_n = S_WPB; w_disp_n = w_b_n; end
      COMPUTE: begin w_st_n = S_OBL; w_disp_n = w_b_n; w_busy_n = 1'b1; end
      SHOW:    begin w_st_n = S_WYN; w_disp_n = w_res_n; end
      ERROR:   begin w_st_n = S_WYN; w_disp_n = 16'hEEEE; w_err_n = 1'b1; end
      default: begin w_st_n = S_WPA; w_disp_n = w_a_n; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ENTER_A;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_acnt  <= '0;
      r_bcnt  <= '0;
      r_tmo   <= '0;
      r_stl   <= SL_ADD;
      r_st    <= S_WPA;
      r_disp  <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_a     <= w_a_n;
      r_b     <= w_b_n;
      r_res   <= w_res_n;
      r_acnt  <= w_acnt_n;
      r_bcnt  <= w_bcnt_n;
      r_tmo   <= w_tmo_n;
      r_stl   <= w_stl_n;
      r_st    <= w_st_n;
      r_disp  <= w_disp_n;
      r_busy  <= w_busy_n;
      r_err   <= w_err_n;
    end
  end

  assign {A1, A2, A3, A4} = r_a;
  assign {B1, B2, B3, B4} = r_b;
  assign ST   = r_st;
  assign ST_L = r_stl;
  assign disp = r_disp;
  assign busy = r_busy;
  assign err  = r_err;

endmodule

// File: tb/tb_calc_key_ctrl.sv
// Directed bench for calc_key_ctrl: drives key events and a hand-driven
// Calkko set/number pair, checking every expectation against fixed values.
module tb_calc_key_ctrl;

  localparam logic [4:0] K_ADD = 5'd10, K_SUB = 5'd11, K_XOR = 5'd12;
  localparam logic [4:0] K_EQ  = 5'd15, K_CLR = 5'd16;
  localparam logic [1:0] WPA = 2'd0, WPB = 2'd1, OBL = 2'd2, WYN = 2'd3;
  localparam logic [2:0] L_ADD = 3'd0, L_SUB = 3'd1, L_XOR = 3'd2;

  logic        clk = 1'b0;
  logic        rst, key_valid, set;
  logic [4:0]  key_code;
  logic [15:0] number;
  logic [3:0]  A1, A2, A3, A4, B1, B2, B3, B4;
  logic [1:0]  ST;
  logic [2:0]  ST_L;
  logic [15:0] disp;
  logic        busy, err;
  int          checks = 0;
  int          errors = 0;

  calc_key_ctrl #(.TIMEOUT(16), .TW(5)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .set(set), .number(number),
    .A1(A1), .A2(A2), .A3(A3), .A4(A4), .B1(B1), .B2(B2), .B3(B3), .B4(B4),
    .ST(ST), .ST_L(ST_L), .disp(disp), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic press(input logic [4:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 5'd0;
  endtask

  task automatic test_reset;
    rst = 1'b1; key_valid = 1'b0; key_code = 5'd0; set = 1'b0; number = 16'h0;
    #12;
    checks++; if ({A1,A2,A3,A4,B1,B2,B3,B4} !== 32'h0) begin errors++; $display("FAIL reset_ops got %h exp 0", {A1,A2,A3,A4,B1,B2,B3,B4}); end
    checks++; if ({ST, ST_L, busy, err} !== {WPA, L_ADD, 1'b0, 1'b0}) begin errors++; $display("FAIL reset_ctl got %b exp %b", {ST,ST_L,busy,err}, {WPA,L_ADD,2'b00}); end
    checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL reset_disp got %h exp 0000", disp); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic;
    set = 1'b1; number = 16'h0006;
    press(5'd5); press(K_ADD); press(5'd1);
    checks++; if ({A4, B4, ST_L} !== {4'd5, 4'd1, L_ADD}) begin errors++; $display("FAIL basic_entry got %h exp %h", {A4,B4,ST_L}, {4'd5,4'd1,L_ADD}); end
    press(K_EQ);
    checks++; if ({ST, busy} !== {OBL, 1'b1}) begin errors++; $display("FAIL basic_compute got %b exp %b", {ST,busy}, {OBL,1'b1}); end
    @(negedge clk);
    checks++; if ({ST, busy, disp} !== {WYN, 1'b0, 16'h0006}) begin errors++; $display("FAIL basic_show got %h exp %h", {ST,busy,disp}, {WYN,1'b0,16'h0006}); end
    set = 1'b0;
  endtask

  task automatic test_chain;
    press(K_SUB);
    checks++; if ({A1,A2,A3,A4,B1,B2,B3,B4} !== 32'h0006_0000) begin errors++; $display("FAIL chain_ops got %h exp 00060000", {A1,A2,A3,A4,B1,B2,B3,B4}); end
    checks++; if ({ST_L, ST} !== {L_SUB, WPB}) begin errors++; $display("FAIL chain_ctl got %b exp %b", {ST_L,ST}, {L_SUB,WPB}); end
    press(5'd2);
    set = 1'b1; number = 16'h0004;
    press(K_EQ);
    @(negedge clk);
    checks++; if ({ST, disp} !== {WYN, 16'h0004}) begin errors++; $display("FAIL chain_show got %h exp %h", {ST,disp}, {WYN,16'h0004}); end
    number = 16'h0002;
    press(K_EQ);
    checks++; if ({A1,A2,A3,A4,B1,B2,B3,B4,ST} !== {32'h0004_0002, OBL}) begin errors++; $display("FAIL chain_repeat got %h exp %h", {A1,A2,A3,A4,B1,B2,B3,B4,ST}, {32'h0004_0002,OBL}); end
    @(negedge clk);
    checks++; if (disp !== 16'h0002) begin errors++; $display("FAIL chain_repeat_res got %h exp 0002", disp); end
    set = 1'b0;
  endtask

  task automatic test_digits;
    press(K_CLR);
    for (int unsigned i = 1; i <= 4; i++) press(5'(i));
    checks++; if ({A1,A2,A3,A4,disp} !== 32'h1234_1234) begin errors++; $display("FAIL digits_four got %h exp 12341234", {A1,A2,A3,A4,disp}); end
    press(5'd5);
    checks++; if ({A1,A2,A3,A4,disp} !== 32'h1234_1234) begin errors++; $display("FAIL digits_full got %h exp 12341234", {A1,A2,A3,A4,disp}); end
    press(5'd20);
    checks++; if ({ST, A1,A2,A3,A4} !== {WPA, 16'h1234}) begin errors++; $display("FAIL digits_ignored_code got %h exp %h", {ST,A1,A2,A3,A4}, {WPA,16'h1234}); end
  endtask

  task automatic test_ops;
    press(K_CLR); press(5'd5); press(K_ADD); press(K_SUB); press(K_XOR); press(5'd3);
    checks++; if ({ST_L, ST} !== {L_XOR, WPB}) begin errors++; $display("FAIL ops_sel got %b exp %b", {ST_L,ST}, {L_XOR,WPB}); end
    checks++; if ({A1,A2,A3,A4,B1,B2,B3,B4,disp} !== 48'h0005_0003_0003) begin errors++; $display("FAIL ops_operands got %h exp 000500030003", {A1,A2,A3,A4,B1,B2,B3,B4,disp}); end
  endtask

  task automatic test_timeout;
    press(K_CLR); press(5'd5); press(K_ADD); press(5'd1);
    set = 1'b0;
    press(K_EQ);
    repeat (15) @(negedge clk);
    checks++; if ({busy, err, ST} !== {1'b1, 1'b0, OBL}) begin errors++; $display("FAIL timeout_early got %b exp %b", {busy,err,ST}, {2'b10,OBL}); end
    @(negedge clk);
    checks++; if ({err, busy, ST, disp} !== {1'b1, 1'b0, WYN, 16'hEEEE}) begin errors++; $display("FAIL timeout_err got %h exp %h", {err,busy,ST,disp}, {2'b10,WYN,16'hEEEE}); end
    press(K_ADD); press(K_EQ);
    checks++; if ({err, disp} !== {1'b1, 16'hEEEE}) begin errors++; $display("FAIL error_ignores_op got %h exp %h", {err,disp}, {1'b1,16'hEEEE}); end
    press(5'd8);
    checks++; if ({ST, err, A1,A2,A3,A4} !== {WPA, 1'b0, 16'h0008}) begin errors++; $display("FAIL error_digit got %h exp %h", {ST,err,A1,A2,A3,A4}, {WPA,1'b0,16'h0008}); end
    press(K_CLR);
    checks++; if ({ST, err, A1,A2,A3,A4,B1,B2,B3,B4} !== {WPA, 1'b0, 32'h0}) begin errors++; $display("FAIL clr_after_err got %h exp %h", {ST,err,A1,A2,A3,A4,B1,B2,B3,B4}, {WPA,1'b0,32'h0}); end
    press(5'd5); press(K_ADD); press(5'd1); press(K_EQ);
    repeat (15) @(negedge clk);
    set = 1'b1; number = 16'h0006;
    @(negedge clk);
    checks++; if ({ST, err, disp} !== {WYN, 1'b0, 16'h0006}) begin errors++; $display("FAIL set_at_expiry got %h exp %h", {ST,err,disp}, {WYN,1'b0,16'h0006}); end
    set = 1'b0;
  endtask

  task automatic test_compute_keys_and_rst;
    press(K_CLR); press(5'd7); press(K_ADD); press(5'd2);
    set = 1'b0;
    press(K_EQ); press(5'd9); press(K_SUB);
    checks++; if ({A1,A2,A3,A4,B1,B2,B3,B4,ST_L,busy} !== {32'h0007_0002, L_ADD, 1'b1}) begin errors++; $display("FAIL compute_keys got %h exp %h", {A1,A2,A3,A4,B1,B2,B3,B4,ST_L,busy}, {32'h0007_0002,L_ADD,1'b1}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({A1,A2,A3,A4,B1,B2,B3,B4,disp} !== 48'h0) begin errors++; $display("FAIL async_rst_ops got %h exp 0", {A1,A2,A3,A4,B1,B2,B3,B4,disp}); end
    checks++; if ({ST, ST_L, busy, err} !== {WPA, L_ADD, 2'b00}) begin errors++; $display("FAIL async_rst_ctl got %b exp %b", {ST,ST_L,busy,err}, {WPA,L_ADD,2'b00}); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++; if ({ST, busy} !== {WPA, 1'b0}) begin errors++; $display("FAIL post_rst_idle got %b exp %b", {ST,busy}, {WPA,1'b0}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_chain();
    test_digits();
    test_ops();
    test_timeout();
    test_compute_keys_and_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
